// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// The serial line is synchronised, frames are decoded by a mid-bit sampling
// FSM, good bytes are pushed into the FIFO and line/overflow problems are
// reported through sticky flags that software clears with i_clr_err.
module uart_rx_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    input  logic       i_rd_en,
    input  logic       i_clr_err,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overrun,
    output logic       o_frame_err
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Start bit is checked half a bit in; data/stop bits one full bit apart.
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser
    logic             r_rxd_meta;
    logic             r_rxd_s;

    // Receive FSM
    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Sticky flags
    logic             r_overrun;
    logic             r_frame_err;

    // Decodes
    logic             w_tmr_half;
    logic             w_tmr_full;
    logic             w_data_smp;
    logic             w_stop_smp;
    logic             w_push;
    logic             w_frame_bad;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_ok;
    logic             w_ovr_set;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= i_rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    assign w_tmr_half  = (r_timer == TMR_HALF);
    assign w_tmr_full  = (r_timer == TMR_FULL);
    assign w_data_smp  = (r_state == S_DATA) && w_tmr_full;
    assign w_stop_smp  = (r_state == S_STOP) && w_tmr_full;
    // The push is decoded from the stop-sample cycle so the byte lands in the
    // FIFO on the same edge that samples the stop bit.
    assign w_push      = w_stop_smp && r_rxd_s;
    assign w_frame_bad = w_stop_smp && !r_rxd_s;

    // Frame decoder: IDLE -> START -> DATA x8 -> STOP, with BREAK absorbing a held-low line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    if (!r_rxd_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tmr_half) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        // A line that is high again mid start bit was a glitch.
                        r_state   <= r_rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_tmr_full) begin
                        r_timer   <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_tmr_full) begin
                        r_timer <= '0;
                        // Returning to IDLE mid stop bit lets a back-to-back
                        // start edge be caught without an idle gap.
                        r_state <= r_rxd_s ? S_IDLE : S_BREAK;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_BREAK: begin
                    r_timer <= '0;
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    // Data shift register, LSB first; a partial byte is simply overwritten by the next frame
    always_ff @(posedge i_clk) begin
        if (w_data_smp) begin
            r_shift[r_bit_idx] <= r_rxd_s;
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr_ok   = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // FIFO storage, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_rdata     = r_mem[r_rd_ptr];
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule
